intpol2_ch_sched: RTL and testbench
===================================

Name: intpol2_ch_sched

Overview:
- Round-robin scheduler that time-shares one intpol2_D4 interpolator core between NCH input/output FIFO channel pairs.
- Selects an eligible channel and drives the core's start/bypass inputs and the channel-select mux index.
- Each grant lasts for a quantum of core output blocks, or a cycle budget in bypass mode.
- Re-arbitrates on quantum expiry, input starvation or channel disable.

Parameters:
NCH, 4, number of channels (2..16)
SELW, 2, width of ch_sel; must satisfy 2^SELW >= NCH
QUANTUM, 8, core_done pulses per grant (interpolating channel)
BYP_CYC, 64, cycles per grant (bypass channel)
STARVE_LIM, 16, consecutive core_stop_empty cycles that end a grant
CNT_W, 8, width of internal counters; must hold max(QUANTUM, BYP_CYC, STARVE_LIM)

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
en  in  1  global scheduler enable
ch_en  in  NCH  per-channel enable
ch_bypass  in  NCH  per-channel bypass mode
ch_empty  in  NCH  input FIFO empty, per channel
ch_afull  in  NCH  output FIFO almost-full, per channel
core_done  in  1  core block-complete pulse
core_stop_empty  in  1  core stalled on empty input
core_start  out  1  one-cycle start pulse to core
core_bypass  out  1  bypass select to core, held for whole grant
ch_sel  out  SELW  granted channel index (FIFO/core mux select)
grant_valid  out  1  ch_sel refers to an active grant
sched_busy  out  1  scheduler not in IDLE
sw_pulse  out  1  one-cycle pulse on every channel switch

Behaviour:
- Reset (async, rstn=0): state=IDLE. All outputs 0, ch_sel=0. last_grant=NCH-1, so the first search starts at ch 0. All counters 0. Reset mid-grant aborts immediately; no core_start is issued.
- elig[i] = ch_en[i] & ~ch_empty[i] & ~ch_afull[i].
- Round-robin: search indices last_grant+1 … last_grant+NCH (mod NCH). Take the first eligible index.
- Outputs are Moore, decoded from registered state/regs:
  - core_start=1 only in START.
  - grant_valid=1 in START, RUN and PARK.
  - sched_busy=1 whenever state≠IDLE.
- States:
  - IDLE: if en, go to ARB.
  - ARB: if any elig, latch grant into ch_sel and last_grant, latch core_bypass=ch_bypass[grant], go to START. Otherwise stay in ARB.
  - START: core_start=1 for exactly 1 cycle; sw_pulse=1 if grant differs from the previous grant. Clear blk_cnt, cyc_cnt, starve_cnt. Go to RUN.
  - RUN:
    - blk_cnt increments on core_done (interpolating grant only).
    - cyc_cnt increments every cycle (bypass grant only).
    - starve_cnt increments while core_stop_empty=1 and clears when it is 0.
    - Exit checks in priority order:
      - (1) en=0 → IDLE.
      - (2) ch_en[grant]=0 → ARB.
      - (3) quantum reached (blk_cnt==QUANTUM or cyc_cnt==BYP_CYC): if any other channel is eligible → ARB; else stay in RUN with counters cleared and no restart.
      - (4) starve_cnt==STARVE_LIM → PARK.
  - PARK: core left stalled; ch_sel held.
    - If an eligible channel other than the grant exists → ARB.
    - Else if elig[grant] → RUN with counters cleared and no core_start (core resumes its own stream).
    - en=0 → IDLE.
- Timing: core_done arriving in START is ignored. A core_done in the same cycle starve_cnt hits its limit is counted first, so the quantum check wins. ch_afull of the granted channel does not end a grant; the core stalls itself.
- Latency: en rises at cycle n with ch 0 eligible → ARB at n+1, START at n+2 (core_start=1, ch_sel=0), RUN at n+3.
- core_bypass and ch_sel change only on the ARB→START transition.

Test Plan:
- Reset, en=1, only ch 2 eligible, interpolating → core_start pulse 2 cycles after en, ch_sel=2, core_bypass=0, grant_valid=1, sw_pulse=1.
- ch 0 and ch 1 both eligible, QUANTUM=8, 8 core_done pulses on ch 0 → ARB, then START on ch 1 with sw_pulse; next quantum returns to ch 0.
- Single eligible ch 3, 8 core_done pulses → stays in RUN, no extra core_start, counters cleared.
- ch 1 in bypass, BYP_CYC=64, ch 2 eligible → core_bypass=1 for exactly 64 RUN cycles, then switch to ch 2 with core_bypass=0.
- core_stop_empty held 16 cycles, no other eligible channel → PARK; ch 1 refilled → RUN with no core_start. Repeat with ch 3 eligible instead → START on ch 3.
- rstn low mid-RUN, and en low mid-RUN → all outputs 0 immediately on reset; en low gives IDLE next cycle with sched_busy=0.

Source files
------------

// File: rtl/intpol2_ch_sched_if.sv
// Control/status bundle between the channel scheduler and its environment
// (FIFO status flags in, core control and mux select out).
interface intpol2_ch_sched_if #(
  parameter int NCH  = 4,
  parameter int SELW = 2
);
  logic            en;
  logic [NCH-1:0]  ch_en;
  logic [NCH-1:0]  ch_bypass;
  logic [NCH-1:0]  ch_empty;
  logic [NCH-1:0]  ch_afull;
  logic            core_done;
  logic            core_stop_empty;
  logic            core_start;
  logic            core_bypass;
  logic [SELW-1:0] ch_sel;
  logic            grant_valid;
  logic            sched_busy;
  logic            sw_pulse;

  modport master (
    output en, ch_en, ch_bypass, ch_empty, ch_afull, core_done, core_stop_empty,
    input  core_start, core_bypass, ch_sel, grant_valid, sched_busy, sw_pulse
  );

  modport slave (
    input  en, ch_en, ch_bypass, ch_empty, ch_afull, core_done, core_stop_empty,
    output core_start, core_bypass, ch_sel, grant_valid, sched_busy, sw_pulse
  );
endinterface

// File: rtl/intpol2_ch_sched.sv
// Round-robin scheduler time-sharing one intpol2_D4 interpolator core between
// NCH FIFO channel pairs; grants last a block quantum or a bypass cycle budget.
module intpol2_ch_sched #(
  parameter int NCH        = 4,
  parameter int SELW       = 2,
  parameter int QUANTUM    = 8,
  parameter int BYP_CYC    = 64,
  parameter int STARVE_LIM = 16,
  parameter int CNT_W      = 8
) (
  input logic               clk,
  input logic               rstn,
  intpol2_ch_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_PARK  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] QUANT_C  = CNT_W'(QUANTUM);
  localparam logic [CNT_W-1:0] BYP_C    = CNT_W'(BYP_CYC);
  localparam logic [CNT_W-1:0] STARVE_C = CNT_W'(STARVE_LIM);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [SELW:0]    NCH_C    = (SELW+1)'(NCH);
  localparam logic [SELW-1:0]  LAST_RST = SELW'(NCH - 1);

  state_t           state_q, state_d;
  logic [SELW-1:0]  ch_sel_q, ch_sel_d;
  logic [SELW-1:0]  last_q, last_d;
  logic             byp_q, byp_d;
  logic             seen_q, seen_d;
  logic             sw_d;
  logic [CNT_W-1:0] blk_q, blk_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             core_start_q;
  logic             grant_valid_q;
  logic             sched_busy_q;
  logic             sw_pulse_q;

  logic [NCH-1:0]   elig_s;
  logic [SELW-1:0]  pick_s;
  logic             any_elig_s;
  logic             other_elig_s;
  logic             quantum_s;
  logic [CNT_W-1:0] blk_inc_s;
  logic [CNT_W-1:0] cyc_inc_s;
  logic [CNT_W-1:0] starve_inc_s;

  // First eligible index after 'last', wrapping modulo NCH (no power-of-two assumption).
  function automatic logic [SELW-1:0] rr_pick(input logic [NCH-1:0] el,
                                              input logic [SELW-1:0] last);
    logic [SELW:0] idx;
    logic          found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      idx = {1'b0, last} + (SELW+1)'(k);
      if (idx >= NCH_C) begin
        idx = idx - NCH_C;
      end else begin
        idx = idx;
      end
      if (!found && el[idx[SELW-1:0]]) begin
        rr_pick = idx[SELW-1:0];
        found   = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  function automatic logic others_elig(input logic [NCH-1:0] el,
                                       input logic [SELW-1:0] grant);
    logic [NCH-1:0] m;
    m        = el;
    m[grant] = 1'b0;
    return |m;
  endfunction

  assign elig_s       = bus.ch_en & ~bus.ch_empty & ~bus.ch_afull;
  assign pick_s       = rr_pick(elig_s, last_q);
  assign any_elig_s   = |elig_s;
  assign other_elig_s = others_elig(elig_s, ch_sel_q);
  assign blk_inc_s    = blk_q + {{(CNT_W-1){1'b0}}, bus.core_done & ~byp_q};
  assign cyc_inc_s    = cyc_q + {{(CNT_W-1){1'b0}}, byp_q};
  assign starve_inc_s = bus.core_stop_empty ? (starve_q + CNT_ONE) : CNT_ZERO;
  // Counting first means a core_done on the starvation-limit cycle lets the quantum win.
  assign quantum_s    = byp_q ? (cyc_inc_s == BYP_C) : (blk_inc_s == QUANT_C);

  // Next-state and grant bookkeeping.
  always_comb begin
    state_d  = state_q;
    ch_sel_d = ch_sel_q;
    last_d   = last_q;
    byp_d    = byp_q;
    seen_d   = seen_q;
    sw_d     = 1'b0;
    blk_d    = blk_q;
    cyc_d    = cyc_q;
    starve_d = starve_q;
    case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          state_d = S_ARB;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARB: begin
        if (any_elig_s) begin
          ch_sel_d = pick_s;
          last_d   = pick_s;
          byp_d    = bus.ch_bypass[pick_s];
          sw_d     = !seen_q || (pick_s != last_q);
          seen_d   = 1'b1;
          state_d  = S_START;
        end else begin
          state_d = S_ARB;
        end
      end
      S_START: begin
        blk_d    = CNT_ZERO;
        cyc_d    = CNT_ZERO;
        starve_d = CNT_ZERO;
        state_d  = S_RUN;
      end
      S_RUN: begin
        blk_d    = blk_inc_s;
        cyc_d    = cyc_inc_s;
        starve_d = starve_inc_s;
        if (!bus.en) begin
          state_d = S_IDLE;
        end else if (!bus.ch_en[ch_sel_q]) begin
          state_d = S_ARB;
        end else if (quantum_s) begin
          if (other_elig_s) begin
            state_d = S_ARB;
          end else begin
            // Sole eligible channel keeps the core without a restart.
            blk_d    = CNT_ZERO;
            cyc_d    = CNT_ZERO;
            starve_d = CNT_ZERO;
            state_d  = S_RUN;
          end
        end else if (starve_inc_s == STARVE_C) begin
          state_d = S_PARK;
        end else begin
          state_d = S_RUN;
        end
      end
      S_PARK: begin
        if (!bus.en) begin
          state_d = S_IDLE;
        end else if (other_elig_s) begin
          state_d = S_ARB;
        end else if (elig_s[ch_sel_q]) begin
          blk_d    = CNT_ZERO;
          cyc_d    = CNT_ZERO;
          starve_d = CNT_ZERO;
          state_d  = S_RUN;
        end else begin
          state_d = S_PARK;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, grant registers and Moore outputs decoded from the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      ch_sel_q      <= {SELW{1'b0}};
      last_q        <= LAST_RST;
      byp_q         <= 1'b0;
      seen_q        <= 1'b0;
      blk_q         <= CNT_ZERO;
      cyc_q         <= CNT_ZERO;
      starve_q      <= CNT_ZERO;
      core_start_q  <= 1'b0;
      grant_valid_q <= 1'b0;
      sched_busy_q  <= 1'b0;
      sw_pulse_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_sel_q      <= ch_sel_d;
      last_q        <= last_d;
      byp_q         <= byp_d;
      seen_q        <= seen_d;
      blk_q         <= blk_d;
      cyc_q         <= cyc_d;
      starve_q      <= starve_d;
      core_start_q  <= (state_d == S_START);
      grant_valid_q <= (state_d == S_START) || (state_d == S_RUN) || (state_d == S_PARK);
      sched_busy_q  <= (state_d != S_IDLE);
      sw_pulse_q    <= sw_d;
    end
  end

  assign bus.core_start  = core_start_q;
  assign bus.core_bypass = byp_q;
  assign bus.ch_sel      = ch_sel_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.sched_busy  = sched_busy_q;
  assign bus.sw_pulse    = sw_pulse_q;

endmodule

// File: tb/tb_intpol2_ch_sched.sv
// Scoreboard bench for intpol2_ch_sched: a behavioural model predicts each
// cycle's outputs and each grant; a monitor pops and compares independently.
module tb_intpol2_ch_sched;
  localparam int NCH        = 4;
  localparam int SELW       = 2;
  localparam int QUANTUM    = 8;
  localparam int BYP_CYC    = 64;
  localparam int STARVE_LIM = 16;
  localparam int CNT_W      = 8;

  localparam int P_IDLE  = 0;
  localparam int P_ARB   = 1;
  localparam int P_START = 2;
  localparam int P_RUN   = 3;
  localparam int P_PARK  = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  intpol2_ch_sched_if #(.NCH(NCH), .SELW(SELW)) bus ();

  intpol2_ch_sched #(
    .NCH(NCH), .SELW(SELW), .QUANTUM(QUANTUM), .BYP_CYC(BYP_CYC),
    .STARVE_LIM(STARVE_LIM), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  typedef struct {
    logic start; logic gv; logic busy; logic sw; logic byp; int sel;
  } exp_t;
  typedef struct {
    int sel; logic byp; logic sw;
  } gr_t;

  exp_t cyc_q[$];
  gr_t  gr_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int   ph, m_grant, m_last, m_blocks, m_cycles, m_starve;
  logic m_byp, m_sw, m_had;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_elig(input int i);
    return bus.ch_en[i] && !bus.ch_empty[i] && !bus.ch_afull[i];
  endfunction

  task automatic model_step();
    exp_t e;
    gr_t  g;
    int   others;
    logic quantum;
    logic found;
    if (!rstn) begin
      ph = P_IDLE; m_grant = 0; m_last = NCH - 1; m_byp = 1'b0; m_sw = 1'b0; m_had = 1'b0;
      m_blocks = 0; m_cycles = 0; m_starve = 0;
    end else begin
      m_sw   = 1'b0;
      others = 0;
      for (int i = 0; i < NCH; i++) if (i != m_grant && m_elig(i)) others++;
      case (ph)
        P_IDLE: if (bus.en) ph = P_ARB;
        P_ARB: begin
          found = 1'b0;
          for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (m_last + k) % NCH;
            if (!found && m_elig(c)) begin
              found   = 1'b1;
              m_sw    = !m_had || (c != m_last);
              m_had   = 1'b1;
              m_grant = c;
              m_last  = c;
              m_byp   = bus.ch_bypass[c];
              ph      = P_START;
              g.sel = c; g.byp = m_byp; g.sw = m_sw;
              gr_q.push_back(g);
            end
          end
        end
        P_START: begin
          m_blocks = 0; m_cycles = 0; m_starve = 0; ph = P_RUN;
        end
        P_RUN: begin
          if (m_byp) m_cycles++;
          else if (bus.core_done) m_blocks++;
          m_starve = bus.core_stop_empty ? m_starve + 1 : 0;
          quantum  = m_byp ? (m_cycles == BYP_CYC) : (m_blocks == QUANTUM);
          if (!bus.en) ph = P_IDLE;
          else if (!bus.ch_en[m_grant]) ph = P_ARB;
          else if (quantum) begin
            if (others > 0) ph = P_ARB;
            else begin m_blocks = 0; m_cycles = 0; m_starve = 0; end
          end else if (m_starve == STARVE_LIM) ph = P_PARK;
        end
        P_PARK: begin
          if (!bus.en) ph = P_IDLE;
          else if (others > 0) ph = P_ARB;
          else if (m_elig(m_grant)) begin
            ph = P_RUN; m_blocks = 0; m_cycles = 0; m_starve = 0;
          end
        end
        default: ph = P_IDLE;
      endcase
    end
    e.start = (ph == P_START);
    e.gv    = (ph == P_START) || (ph == P_RUN) || (ph == P_PARK);
    e.busy  = (ph != P_IDLE);
    e.sw    = m_sw;
    e.byp   = m_byp;
    e.sel   = m_grant;
    cyc_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // monitor: compares DUT outputs against the scoreboard on the falling edge
  initial begin : monitor
    exp_t e;
    gr_t  g;
    forever begin
      @(negedge clk);
      if (cyc_q.size() == 0) begin
        if (rstn) chk("exp_queue_empty", 32'd1, 32'd0);
      end else begin
        e = cyc_q.pop_front();
        chk("core_start",  32'(bus.core_start),  32'(e.start));
        chk("grant_valid", 32'(bus.grant_valid), 32'(e.gv));
        chk("sched_busy",  32'(bus.sched_busy),  32'(e.busy));
        chk("sw_pulse",    32'(bus.sw_pulse),    32'(e.sw));
        chk("core_bypass", 32'(bus.core_bypass), 32'(e.byp));
        chk("ch_sel",      32'(bus.ch_sel),      32'(e.sel));
      end
      if (bus.core_start === 1'b1) begin
        if (gr_q.size() == 0) chk("grant_queue_empty", 32'd1, 32'd0);
        else begin
          g = gr_q.pop_front();
          chk("grant_ch",  32'(bus.ch_sel),      32'(g.sel));
          chk("grant_byp", 32'(bus.core_bypass), 32'(g.byp));
          chk("grant_sw",  32'(bus.sw_pulse),    32'(g.sw));
        end
      end
    end
  end

  task automatic tick(input logic d, input logic s);
    @(posedge clk);
    #1;
    bus.core_done       = d;
    bus.core_stop_empty = s;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("reset_outputs",
        32'({bus.core_start, bus.core_bypass, bus.ch_sel, bus.grant_valid, bus.sched_busy, bus.sw_pulse}),
        32'd0);
    cyc_q.delete();
    gr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin : stim
    int lat, starts, cnt;
    logic found, stop_st;
    int seq[$];
    bus.en = 1'b0; bus.ch_en = '0; bus.ch_bypass = '0; bus.ch_empty = '0; bus.ch_afull = '0;
    bus.core_done = 1'b0; bus.core_stop_empty = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    // only ch 2 eligible: start two cycles after en, then hold the core
    tick(1'b0, 1'b0);
    bus.en = 1'b1; bus.ch_en = 4'b0100;
    lat = 0;
    for (int t = 1; t <= 10; t++) begin
      tick(1'b0, 1'b0);
      if (bus.core_start && lat == 0) lat = t;
    end
    chk("start_latency", 32'(lat), 32'd2);
    starts = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1'(i % 2), 1'b0);
      if (bus.core_start) starts++;
    end
    chk("single_ch_no_restart", 32'(starts), 32'd0);

    // en low mid-RUN
    bus.en = 1'b0;
    tick(1'b0, 1'b0);
    chk("en_low_idle", 32'(bus.sched_busy), 32'd0);

    // ch 0 and ch 1 alternate on quantum expiry
    bus.ch_en = 4'b0011; bus.en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick(1'(i % 2), 1'b0);
      if (bus.core_start) seq.push_back(int'(bus.ch_sel));
    end
    chk("rr_grants", 32'(seq.size() >= 3), 32'd1);
    if (seq.size() >= 3) begin
      chk("rr_first",  32'(seq[0]), 32'd0);
      chk("rr_second", 32'(seq[1]), 32'd1);
      chk("rr_third",  32'(seq[2]), 32'd0);
    end

    // reset mid-RUN
    do_reset();
    bus.en = 1'b0;

    // bypass ch 1 holds the core for exactly BYP_CYC RUN cycles, then ch 2
    tick(1'b0, 1'b0);
    bus.ch_en = 4'b0110; bus.ch_bypass = 4'b0010; bus.en = 1'b1;
    cnt = 0; found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick(1'b0, 1'b0);
      if (bus.core_start && !bus.core_bypass) found = 1'b1;
      else if (bus.core_bypass && bus.grant_valid && !bus.core_start) cnt++;
    end
    chk("byp_switch_seen", 32'(found), 32'd1);
    chk("byp_run_cycles", 32'(cnt), 32'(BYP_CYC));
    chk("byp_next_ch", 32'(bus.ch_sel), 32'd2);

    // starvation parks ch 1; refill resumes without a start
    bus.ch_bypass = 4'b0000; bus.ch_en = 4'b0010;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b0, 1'b1);
      if (bus.core_start) found = 1'b1;
    end
    chk("park_grant_ch1", 32'(bus.ch_sel), 32'd1);
    bus.ch_empty = 4'b0010;
    for (int i = 0; i < 25; i++) tick(1'b0, 1'b1);
    chk("park_grant_valid", 32'(bus.grant_valid), 32'd1);
    bus.ch_empty = 4'b0000;
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0);
      if (bus.core_start) starts++;
    end
    chk("park_resume_no_start", 32'(starts), 32'd0);
    bus.ch_empty = 4'b0010;
    for (int i = 0; i < 25; i++) tick(1'b0, 1'b1);
    bus.ch_en = 4'b1010;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b0, 1'b1);
      if (bus.core_start) found = 1'b1;
    end
    chk("park_switch_seen", 32'(found), 32'd1);
    chk("park_switch_ch3", 32'(bus.ch_sel), 32'd3);

    // randomized traffic against the model
    bus.ch_empty = '0; bus.ch_en = 4'b1111; stop_st = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) stop_st = ~stop_st;
      tick(1'($urandom_range(0, 2) == 0), stop_st);
      bus.en       = 1'($urandom_range(0, 99) != 0);
      bus.ch_empty = NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
      bus.ch_afull = ($urandom_range(0, 9) == 0) ? NCH'($urandom) : '0;
      if ($urandom_range(0, 49) == 0) begin
        bus.ch_en     = NCH'($urandom);
        bus.ch_bypass = NCH'($urandom) & NCH'($urandom);
      end
      if ($urandom_range(0, 1999) == 0) do_reset();
    end

    repeat (3) tick(1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
